// File: rtl/rs_alu_pool_pkg.sv
// Shared definitions for the ALU reservation station: default widths, ALU op codes,
// the UNLOCKED tag value and the default-width entry layout.
package rs_alu_pool_pkg;

  localparam int P_DATA_W = 32;
  localparam int P_TAG_W  = 5;
  localparam int P_OP_W   = 6;
  localparam int P_ADDR_W = 32;
  localparam int P_REGA_W = 5;

  // A tag of all ones means the operand value is already valid.
  localparam logic [P_TAG_W-1:0] UNLOCKED = '1;

  localparam logic [P_OP_W-1:0] ALU_ADD  = 6'd0;
  localparam logic [P_OP_W-1:0] ALU_SUB  = 6'd1;
  localparam logic [P_OP_W-1:0] ALU_AND  = 6'd2;
  localparam logic [P_OP_W-1:0] ALU_OR   = 6'd3;
  localparam logic [P_OP_W-1:0] ALU_XOR  = 6'd4;
  localparam logic [P_OP_W-1:0] ALU_SLL  = 6'd5;
  localparam logic [P_OP_W-1:0] ALU_SRL  = 6'd6;
  localparam logic [P_OP_W-1:0] ALU_SRA  = 6'd7;
  localparam logic [P_OP_W-1:0] ALU_SLT  = 6'd8;
  localparam logic [P_OP_W-1:0] ALU_SLTU = 6'd9;

  typedef struct packed {
    logic [P_ADDR_W-1:0] pc;
    logic [P_OP_W-1:0]   op;
    logic [P_TAG_W-1:0]  tagx;
    logic [P_DATA_W-1:0] datax;
    logic [P_TAG_W-1:0]  tagy;
    logic [P_DATA_W-1:0] datay;
    logic [P_TAG_W-1:0]  tagw;
    logic [P_REGA_W-1:0] target;
  } rs_entry_t;

endpackage

// File: rtl/rs_alu_pool_wakeup.sv
// Single-operand CDB match: reports whether any valid broadcast carries this tag and
// returns its data, lowest port winning. UNLOCKED tags never match.
module rs_pool_wakeup
  import rs_alu_pool_pkg::*;
#(
  parameter int CDB_CNT = 3,
  parameter int TAG_W   = P_TAG_W,
  parameter int DATA_W  = P_DATA_W
) (
  input  logic [TAG_W-1:0]          i_tag,
  input  logic [CDB_CNT-1:0]        i_cdb_valid,
  input  logic [CDB_CNT*TAG_W-1:0]  i_cdb_tag,
  input  logic [CDB_CNT*DATA_W-1:0] i_cdb_data,
  output logic                      o_hit,
  output logic [DATA_W-1:0]         o_data
);

  localparam logic [TAG_W-1:0] L_UNL = '1;

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    // Descending scan so the lowest matching port is the last writer.
    for (int k = CDB_CNT - 1; k >= 0; k--) begin
      if (i_cdb_valid[k] && (i_cdb_tag[k*TAG_W +: TAG_W] == i_tag) && (i_tag != L_UNL)) begin
        o_hit  = 1'b1;
        o_data = i_cdb_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/rs_alu_pool.sv
// Shared, age-ordered ALU reservation station: compacting queue with CDB wakeup,
// allocation bypass and oldest-ready issue.
module rs_alu_pool
  import rs_alu_pool_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CDB_CNT = 3,
  parameter int DATA_W  = P_DATA_W,
  parameter int TAG_W   = P_TAG_W,
  parameter int OP_W    = P_OP_W,
  parameter int ADDR_W  = P_ADDR_W,
  parameter int REGA_W  = P_REGA_W,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int SEL_W  = $clog2(DEPTH)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rdy,
  input  logic                      i_flush,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [ADDR_W-1:0]         i_in_pc,
  input  logic [OP_W-1:0]           i_in_op,
  input  logic [TAG_W-1:0]          i_in_tagx,
  input  logic [TAG_W-1:0]          i_in_tagy,
  input  logic [DATA_W-1:0]         i_in_datax,
  input  logic [DATA_W-1:0]         i_in_datay,
  input  logic [TAG_W-1:0]          i_in_tagw,
  input  logic [REGA_W-1:0]         i_in_target,
  input  logic [CDB_CNT-1:0]        i_cdb_valid,
  input  logic [CDB_CNT*TAG_W-1:0]  i_cdb_tag,
  input  logic [CDB_CNT*DATA_W-1:0] i_cdb_data,
  output logic                      o_issue_valid,
  input  logic                      i_issue_ready,
  output logic [ADDR_W-1:0]         o_issue_pc,
  output logic [OP_W-1:0]           o_issue_op,
  output logic [DATA_W-1:0]         o_issue_datax,
  output logic [DATA_W-1:0]         o_issue_datay,
  output logic [TAG_W-1:0]          o_issue_tagw,
  output logic [REGA_W-1:0]         o_issue_target,
  output logic [CNT_W-1:0]          o_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tagx;
    logic [DATA_W-1:0] datax;
    logic [TAG_W-1:0]  tagy;
    logic [DATA_W-1:0] datay;
    logic [TAG_W-1:0]  tagw;
    logic [REGA_W-1:0] target;
  } ent_t;

  localparam logic [TAG_W-1:0] L_UNL   = '1;
  localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);

  ent_t              r_ent [DEPTH];
  logic [CNT_W-1:0]  r_count;

  ent_t              w_wake [DEPTH+1];
  ent_t              w_nxt  [DEPTH];
  ent_t              w_new;
  logic [DEPTH-1:0]  w_hitx, w_hity;
  logic [DATA_W-1:0] w_cdbx [DEPTH];
  logic [DATA_W-1:0] w_cdby [DEPTH];
  logic              w_bhx, w_bhy;
  logic [DATA_W-1:0] w_bdx, w_bdy;
  logic [SEL_W-1:0]  w_sel;
  logic              w_any;
  logic              w_issue_fire, w_alloc_fire;
  logic [CNT_W-1:0]  w_wr;

  for (genvar e = 0; e < DEPTH; e++) begin : g_wake
    rs_pool_wakeup #(.CDB_CNT(CDB_CNT), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_x (
      .i_tag(r_ent[e].tagx), .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag),
      .i_cdb_data(i_cdb_data), .o_hit(w_hitx[e]), .o_data(w_cdbx[e]));
    rs_pool_wakeup #(.CDB_CNT(CDB_CNT), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_y (
      .i_tag(r_ent[e].tagy), .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag),
      .i_cdb_data(i_cdb_data), .o_hit(w_hity[e]), .o_data(w_cdby[e]));
  end

  rs_pool_wakeup #(.CDB_CNT(CDB_CNT), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_bypass_x (
    .i_tag(i_in_tagx), .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag),
    .i_cdb_data(i_cdb_data), .o_hit(w_bhx), .o_data(w_bdx));
  rs_pool_wakeup #(.CDB_CNT(CDB_CNT), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_bypass_y (
    .i_tag(i_in_tagy), .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag),
    .i_cdb_data(i_cdb_data), .o_hit(w_bhy), .o_data(w_bdy));

  // Oldest ready entry wins; readiness uses stored tags only.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < r_count) && (r_ent[i].tagx == L_UNL) && (r_ent[i].tagy == L_UNL)) begin
        w_sel = SEL_W'(i);
        w_any = 1'b1;
      end
    end
  end

  assign o_in_ready     = i_rdy && (r_count < L_DEPTH);
  assign o_issue_valid  = i_rdy && w_any;
  assign o_issue_pc     = o_issue_valid ? r_ent[w_sel].pc     : '0;
  assign o_issue_op     = o_issue_valid ? r_ent[w_sel].op     : '0;
  assign o_issue_datax  = o_issue_valid ? r_ent[w_sel].datax  : '0;
  assign o_issue_datay  = o_issue_valid ? r_ent[w_sel].datay  : '0;
  assign o_issue_tagw   = o_issue_valid ? r_ent[w_sel].tagw   : '0;
  assign o_issue_target = o_issue_valid ? r_ent[w_sel].target : '0;
  assign o_count        = r_count;

  assign w_issue_fire = o_issue_valid && i_issue_ready;
  assign w_alloc_fire = i_in_valid && o_in_ready;
  assign w_wr         = w_issue_fire ? (r_count - CNT_W'(1)) : r_count;

  always_comb begin
    w_new.pc     = i_in_pc;
    w_new.op     = i_in_op;
    w_new.tagx   = w_bhx ? L_UNL : i_in_tagx;
    w_new.datax  = w_bhx ? w_bdx : i_in_datax;
    w_new.tagy   = w_bhy ? L_UNL : i_in_tagy;
    w_new.datay  = w_bhy ? w_bdy : i_in_datay;
    w_new.tagw   = i_in_tagw;
    w_new.target = i_in_target;
    // Extra slot lets the top entry shift in an empty value without a range guard.
    w_wake[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wake[i] = r_ent[i];
      if (w_hitx[i]) begin
        w_wake[i].tagx  = L_UNL;
        w_wake[i].datax = w_cdbx[i];
      end
      if (w_hity[i]) begin
        w_wake[i].tagy  = L_UNL;
        w_wake[i].datay = w_cdby[i];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = (w_issue_fire && (SEL_W'(i) >= w_sel)) ? w_wake[i+1] : w_wake[i];
      if (w_alloc_fire && (CNT_W'(i) == w_wr)) w_nxt[i] = w_new;
    end
  end

  // Flush clears exactly like reset, and it does not wait for rdy.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i]      <= '0;
        r_ent[i].tagx <= L_UNL;
        r_ent[i].tagy <= L_UNL;
      end
    end else if (i_rdy) begin
      r_count <= r_count + CNT_W'(w_alloc_fire) - CNT_W'(w_issue_fire);
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_nxt[i];
    end
  end

endmodule

// File: tb/tb_rs_alu_pool.sv
// Bench for rs_alu_pool: directed scenarios then random traffic, every cycle compared
// against a queue-based model of the pool.
module tb_rs_alu_pool;
  import rs_alu_pool_pkg::*;

  localparam int DEPTH = 4;
  localparam int CDB = 3;
  localparam logic [4:0] U = 5'h1f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, flush, in_valid, in_ready, issue_valid, issue_ready;
  logic [31:0] in_pc, in_datax, in_datay;
  logic [5:0]  in_op;
  logic [4:0]  in_tagx, in_tagy, in_tagw, in_target;
  logic [2:0]  cdb_valid;
  logic [14:0] cdb_tag;
  logic [95:0] cdb_data;
  logic [31:0] o_pc, o_dx, o_dy;
  logic [5:0]  o_op;
  logic [4:0]  o_tw, o_tg;
  logic [2:0]  count;

  rs_alu_pool dut (
    .i_clk(clk), .i_rst(rst), .i_rdy(rdy), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_pc(in_pc), .i_in_op(in_op),
    .i_in_tagx(in_tagx), .i_in_tagy(in_tagy), .i_in_datax(in_datax), .i_in_datay(in_datay),
    .i_in_tagw(in_tagw), .i_in_target(in_target),
    .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag), .i_cdb_data(cdb_data),
    .o_issue_valid(issue_valid), .i_issue_ready(issue_ready),
    .o_issue_pc(o_pc), .o_issue_op(o_op), .o_issue_datax(o_dx), .o_issue_datay(o_dy),
    .o_issue_tagw(o_tw), .o_issue_target(o_tg), .o_count(count));

  typedef struct {
    logic [31:0] pc; logic [5:0] op;
    logic [4:0] tx; logic [31:0] dx;
    logic [4:0] ty; logic [31:0] dy;
    logic [4:0] tw; logic [4:0] tg;
  } ent_t;

  ent_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void cdb_lookup(input logic [4:0] t, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d = '0;
    if (t == U) return;
    for (int k = 0; k < CDB; k++) begin
      if (!hit && cdb_valid[k] && cdb_tag[k*5 +: 5] == t) begin
        hit = 1'b1;
        d = cdb_data[k*32 +: 32];
      end
    end
  endfunction

  // Check outputs against the model, take one clock edge, advance the model.
  task automatic step();
    int idx;
    logic ev, irdy, h;
    logic [31:0] d;
    logic [111:0] exp_f;
    ent_t e;
    #1;
    idx = -1;
    foreach (q[i]) if (idx < 0 && q[i].tx == U && q[i].ty == U) idx = i;
    ev = rdy && (idx >= 0);
    irdy = rdy && (q.size() < DEPTH);
    exp_f = '0;
    if (ev) exp_f = {q[idx].pc, q[idx].op, q[idx].dx, q[idx].dy, q[idx].tw, q[idx].tg};
    chk("count", count, q.size());
    chk("in_ready", in_ready, irdy);
    chk("issue_valid", issue_valid, ev);
    chk("issue_fields", {o_pc, o_op, o_dx, o_dy, o_tw, o_tg}, exp_f);
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
    end else if (rdy) begin
      foreach (q[i]) begin
        cdb_lookup(q[i].tx, h, d);
        if (h) begin q[i].tx = U; q[i].dx = d; end
        cdb_lookup(q[i].ty, h, d);
        if (h) begin q[i].ty = U; q[i].dy = d; end
      end
      if (ev && issue_ready) q.delete(idx);
      if (in_valid && irdy) begin
        e = '{pc: in_pc, op: in_op, tx: in_tagx, dx: in_datax, ty: in_tagy, dy: in_datay,
              tw: in_tagw, tg: in_target};
        cdb_lookup(in_tagx, h, d);
        if (h) begin e.tx = U; e.dx = d; end
        cdb_lookup(in_tagy, h, d);
        if (h) begin e.ty = U; e.dy = d; end
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic set_alloc(input logic [31:0] pc, input logic [5:0] op,
                           input logic [4:0] tx, input logic [31:0] dx,
                           input logic [4:0] ty, input logic [31:0] dy, input logic [4:0] tw);
    in_valid = 1'b1; in_pc = pc; in_op = op;
    in_tagx = tx; in_datax = dx; in_tagy = ty; in_datay = dy;
    in_tagw = tw; in_target = tw + 5'd1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    cdb_valid = '0;
    issue_ready = 1'b0;
  endtask

  task automatic cdb(input int k, input logic [4:0] t, input logic [31:0] d);
    cdb_valid[k] = 1'b1;
    cdb_tag[k*5 +: 5] = t;
    cdb_data[k*32 +: 32] = d;
  endtask

  function automatic logic [4:0] rand_tag();
    return ($urandom_range(0, 2) == 0) ? U : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; issue_ready = 1'b0;
    in_pc = '0; in_op = '0; in_tagx = U; in_tagy = U; in_datax = '0; in_datay = '0;
    in_tagw = '0; in_target = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Ready-on-arrival ADD.
    set_alloc(32'h100, ALU_ADD, U, 32'd3, U, 32'd4, 5'd1);
    step();
    idle(); issue_ready = 1'b1;
    #1 chk("add_datax", o_dx, 32'd3);
    step();
    chk("add_count_after_fire", count, 3'd0);
    step();

    // Wakeup through CDB port 1.
    set_alloc(32'h200, ALU_SUB, 5'd7, 32'd0, U, 32'd9, 5'd2);
    step();
    idle(); step();
    cdb(1, 5'd7, 32'hDEAD); step();
    idle(); issue_ready = 1'b1;
    #1 chk("cdb_datax", o_dx, 32'hDEAD);
    step();

    // Younger ready entry overtakes an older waiting one.
    idle();
    set_alloc(32'h300, ALU_AND, 5'd2, 32'd0, U, 32'd1, 5'd3);
    step();
    set_alloc(32'h400, ALU_OR, U, 32'd5, U, 32'd6, 5'd4);
    step();
    idle(); issue_ready = 1'b1;
    #1 chk("b_first", o_pc, 32'h400);
    step();
    cdb(0, 5'd2, 32'h22); step();
    idle(); issue_ready = 1'b1;
    #1 chk("a_second", o_pc, 32'h300);
    step();
    step();

    // Fill, then try a fifth allocation.
    idle();
    for (int k = 0; k < 4; k++) begin
      set_alloc(32'h500 + k, ALU_XOR, 5'(10 + k), 32'd0, U, 32'd0, 5'(k));
      step();
    end
    set_alloc(32'h5FF, ALU_ADD, U, 32'd1, U, 32'd1, 5'd9);
    #1 chk("full_in_ready", in_ready, 1'b0);
    step();
    idle(); cdb(2, 5'd10, 32'hA0); step();
    idle(); issue_ready = 1'b1; step();
    idle();
    #1 chk("in_ready_back", in_ready, 1'b1);
    step();

    // Same-cycle bypass on allocation.
    set_alloc(32'h600, ALU_SLL, U, 32'd1, 5'd9, 32'd0, 5'd5);
    cdb(0, 5'd9, 32'h55); step();
    idle(); issue_ready = 1'b1;
    #1 chk("bypass_datay", o_dy, 32'h55);
    step();

    // Flush with three entries, alloc and issue_ready all active.
    idle();
    flush = 1'b1; issue_ready = 1'b1;
    set_alloc(32'h700, ALU_ADD, U, 32'd1, U, 32'd2, 5'd6);
    step();
    flush = 1'b0; idle();
    #1 chk("flush_count", count, 3'd0);
    step();

    // rdy low freezes a pool holding one ready entry.
    set_alloc(32'h800, ALU_SUB, U, 32'd8, U, 32'd8, 5'd7);
    step();
    rdy = 1'b0; issue_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cdb(0, 5'($urandom_range(0, 7)), $urandom);
      step();
    end
    chk("frozen_count", count, 3'd1);
    rdy = 1'b1; idle(); step();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      in_valid = 1'($urandom_range(0, 1));
      in_pc = $urandom; in_op = 6'($urandom_range(0, 9));
      in_tagx = rand_tag(); in_datax = $urandom;
      in_tagy = rand_tag(); in_datay = $urandom;
      in_tagw = 5'($urandom_range(0, 31)); in_target = 5'($urandom_range(0, 31));
      for (int k = 0; k < CDB; k++) begin
        cdb_valid[k] = ($urandom_range(0, 2) == 0);
        cdb_tag[k*5 +: 5] = rand_tag();
        cdb_data[k*32 +: 32] = $urandom;
      end
      issue_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_alu_pool.md
# rs_alu_pool

Parametrised ALU reservation station. It holds up to DEPTH decoded ALU instructions and captures operand results from CDB_CNT common-data-bus ports. Each cycle it issues the oldest instruction whose operands are both resolved to one ALU executor through a valid/ready handshake. It sits between the dispatcher/allocator and the ALU execute stage, replacing fixed one-slot-per-ALU stations with a shared, age-ordered pool.

## Interface
Parameters:
- DEPTH, 4: number of entries, ≥2.
- CDB_CNT, 3: number of result broadcast ports.
- DATA_W, 32: operand width.
- TAG_W, 5: rename tag width. The all-ones tag is UNLOCKED, meaning the operand value is valid.
- OP_W, 6: width of the internal op encoding.
- ADDR_W, 32: PC width.
- REGA_W, 5: destination register address width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; low freezes the block.
- flush  in  1  synchronous clear of all entries (misprediction).
- in_valid  in  1  allocation request.
- in_ready  out  1  high when count < DEPTH and rdy.
- in_pc  in  ADDR_W  instruction PC.
- in_op  in  OP_W  ALU operation.
- in_tagx, in_tagy  in  TAG_W  operand tags.
- in_datax, in_datay  in  DATA_W  operand values, meaningful only when the matching tag is UNLOCKED.
- in_tagw  in  TAG_W  result tag.
- in_target  in  REGA_W  destination register.
- cdb_valid  in  CDB_CNT  per-port broadcast valid.
- cdb_tag  in  CDB_CNT*TAG_W  packed broadcast tags, port 0 in the LSBs.
- cdb_data  in  CDB_CNT*DATA_W  packed broadcast data.
- issue_valid  out  1  an entry is ready to issue.
- issue_ready  in  1  executor accepts.
- issue_pc, issue_op, issue_datax, issue_datay, issue_tagw, issue_target  out  —  fields of the selected entry.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Storage is a compacting queue. Entry 0 is the oldest; entries 0..count-1 are valid.
- Entry fields: pc, op, tagx, datax, tagy, datay, tagw, target.
- Wakeup, every enabled cycle: for each valid entry operand whose tag is not UNLOCKED, if any cdb_valid[k] is set and cdb_tag[k] equals that tag, latch cdb_data[k] and set the tag to UNLOCKED.
  - If several ports match the same tag, the lowest k wins.
  - A CDB carrying tag UNLOCKED is ignored.
- Allocation bypass: incoming in_tagx/in_tagy are compared against the CDB in the same cycle. A match is stored already UNLOCKED with the CDB data, so a result broadcast during allocation is never lost.
- Ready(e) = valid(e) and tagx(e) == UNLOCKED and tagy(e) == UNLOCKED, judged on the stored state only.
- Select: the lowest-index ready entry, through a combinational priority encoder. issue_valid = rdy and any ready entry. issue_* fields show the selected entry; they are all-zero when issue_valid is low.
- Issue fire = issue_valid and issue_ready. The selected entry is removed, and entries above it shift down by one while receiving their wakeups in the same cycle.
- Allocation fire = in_valid and in_ready. The new entry is written at index count, or count-1 if an issue fires in the same cycle.
- count next value = count + alloc_fire − issue_fire.
- Priority order: rst > flush > normal operation.
  - flush clears count and every entry to zero. Allocation and issue in that cycle are dropped, and issue_valid still shows the pre-flush value.
- rdy low: in_ready = 0 and issue_valid = 0. No state changes, and CDB inputs are ignored.

## Timing
- Reset state: count = 0, all entries zeroed with tags UNLOCKED, in_ready = 1 once rdy is high, issue_valid = 0, every issue_* output 0.
- Allocation to earliest issue: 1 cycle. An entry written with both operands resolved (directly or through bypass) is visible on issue_valid in the next cycle.
- CDB to issue: 1 cycle. A broadcast at edge N makes the entry eligible at edge N+1.
- Full: in_ready is low when count == DEPTH, even if an issue fires in that cycle. There is no same-cycle free-and-refill.
- Empty: issue_valid is low. Simultaneous allocation and CDB on an empty pool behaves exactly as described under bypass.
- Reset or flush mid-operation takes effect at the next edge. No partial shift is retained.

## Structure
- A shared package or header holds: the UNLOCKED definition (tag all-ones), the op encoding width and ALU op codes, and the packed RS entry struct/field widths.
- One sub-module, rs_pool_wakeup: a combinational single-operand CDB match (tag, CDB bus → hit, data). It is instantiated 2×DEPTH + 2 times: both operands of every entry plus the allocation bypass.
- Select and compaction stay in the top level.

## Test plan
- Reset, then allocate op=ADD with x: tag=UNLOCKED data=3 and y: tag=UNLOCKED data=4 → issue_valid=1 on the next cycle with datax=3, datay=4, and count goes 1→0 on the fire.
- Allocate an entry with tagx=7. Drive cdb_valid[1]=1, cdb_tag[1]=7, cdb_data[1]=0xDEAD two cycles later → issue_valid is high one cycle after the broadcast with issue_datax=0xDEAD.
- Allocate A (waiting on tag 2), then B (ready) → B issues first. Then broadcast tag 2 → A issues. The compaction moves A to index 0 with count correct throughout.
- Fill 4 entries, all waiting, with DEPTH=4 → in_ready=0 and the in_valid request is ignored. Broadcasting one tag lets one entry issue, and in_ready returns high the cycle after.
- Allocate with in_tagy=9 while cdb_tag[0]=9, data=0x55 in the same cycle → the entry issues next cycle with datay=0x55.
- With 3 entries and flush asserted together with in_valid and issue_ready → count=0 next cycle, nothing issued and nothing stored. Holding rdy low for 5 cycles freezes count and issue_valid at 0.
